// File: rtl/sar_search_if.sv
// Handshake bundle between sar_search and its environment: start/done control,
// the probe/cmp_lt comparator loop and the signed result.
interface sar_search_if #(
  parameter int N = 32
);
  logic                start;
  logic                cmp_lt;
  logic signed [N-1:0] probe;
  logic                busy;
  logic                done;
  logic signed [N-1:0] result;
  logic                found;

  modport master (
    output start, cmp_lt,
    input  probe, busy, done, result, found
  );

  modport slave (
    input  start, cmp_lt,
    output probe, busy, done, result, found
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search for the largest signed value below a hidden
// target, driven through an external signed less-than comparator.
module sar_search #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, VERIFY, DONE} state_t;

  localparam int             IW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]   MSB = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]  TOP = IW'(N - 1);

  state_t              state, state_nxt;
  logic [N-1:0]        acc, acc_nxt;
  logic [IW-1:0]       idx, idx_nxt;
  logic signed [N-1:0] probe_r, probe_nxt;
  logic signed [N-1:0] result_r, result_nxt;
  logic                found_r, found_nxt;
  logic                busy_r, busy_nxt;
  logic                done_r, done_nxt;

  // Offset-binary <-> two's complement is just an MSB flip, so no adder is needed.
  function automatic logic signed [N-1:0] flip(input logic [N-1:0] u);
    return $signed(u ^ MSB);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      idx      <= '0;
      probe_r  <= '0;
      result_r <= '0;
      found_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      idx      <= idx_nxt;
      probe_r  <= probe_nxt;
      result_r <= result_nxt;
      found_r  <= found_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SEARCH;
      SEARCH:  if (idx == '0) state_nxt = VERIFY;
      VERIFY:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt    = acc;
    idx_nxt    = idx;
    result_nxt = result_r;
    found_nxt  = found_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt = '0;
          idx_nxt = TOP;
        end
      end
      SEARCH: begin
        if (bus.cmp_lt) acc_nxt = acc | (ONE << idx);
        if (idx != '0) idx_nxt = idx - 1'b1;
      end
      VERIFY: begin
        found_nxt  = bus.cmp_lt;
        result_nxt = flip(acc);
      end
      default: ;
    endcase

    // Outputs are registered: derive them from the state being entered.
    probe_nxt = '0;
    case (state_nxt)
      SEARCH:  probe_nxt = flip(acc_nxt | (ONE << idx_nxt));
      VERIFY:  probe_nxt = flip(acc_nxt);
      default: ;
    endcase
    busy_nxt = (state_nxt == SEARCH) || (state_nxt == VERIFY);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.probe  = probe_r;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.found  = found_r;

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search at N=8 and N=32 with a behavioural comparator.
module tb_sar_search;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sar_search_if #(.N(8))  b8 ();
  sar_search_if #(.N(32)) b32 ();

  logic signed [7:0]  tgt8;
  logic signed [31:0] tgt32;

  assign b8.cmp_lt  = ($signed(b8.probe)  < tgt8);
  assign b32.cmp_lt = ($signed(b32.probe) < tgt32);

  sar_search #(.N(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  sar_search #(.N(32)) u32 (.clk(clk), .rst(rst), .bus(b32.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [31:0] res;
    logic               found;
    int                 cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;

  int pseq[9] = '{0, 64, 32, 16, 8, 4, 6, 5, 4};

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic signed [63:0] get_probe(input int w);
    if (w == 8) get_probe = b8.probe;
    else        get_probe = b32.probe;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 8) ? b8.done : b32.done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? b8.busy : b32.busy;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 8) b8.start = v;
    else        b32.start = v;
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (b8.done === 1'b1) begin
      check("n8_done_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        check("n8_result", b8.result, e8.res);
        check("n8_found", b8.found, e8.found);
        check("n8_latency", cyc, e8.cyc);
        check("n8_busy_in_done", b8.busy, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (b32.done === 1'b1) begin
      check("n32_done_expected", q32.size() > 0, 1);
      if (q32.size() > 0) begin
        e32 = q32.pop_front();
        check("n32_result", b32.result, e32.res);
        check("n32_found", b32.found, e32.found);
        check("n32_latency", cyc, e32.cyc);
        check("n32_busy_in_done", b32.busy, 0);
      end
    end
  end

  // One full search; hold start high throughout when hammer is set.
  task automatic search(input int w, input logic signed [31:0] t,
                        input logic signed [31:0] er, input logic ef,
                        input bit hammer, input bit chk_probe);
    exp_t x;
    int   i;
    @(negedge clk);
    if (w == 8) tgt8 = t[7:0];
    else        tgt32 = t;
    set_start(w, 1'b1);
    x.res   = er;
    x.found = ef;
    x.cyc   = cyc + w + 2;
    if (w == 8) q8.push_back(x);
    else        q32.push_back(x);
    @(negedge clk);
    check("busy_after_start", get_busy(w), 1);
    if (!hammer) set_start(w, 1'b0);
    i = 0;
    while (get_done(w) !== 1'b1 && i < w + 4) begin
      if (chk_probe && i < 9) check("n8_probe_seq", get_probe(w), pseq[i]);
      i++;
      @(negedge clk);
    end
    check("done_seen", get_done(w), 1);
    check("probe_in_done", get_probe(w), 0);
    set_start(w, 1'b0);
  endtask

  initial begin
    int                 w;
    logic signed [31:0] mn, mx, t;
    rst = 1'b1;
    b8.start = 1'b0;
    b32.start = 1'b0;
    tgt8 = '0;
    tgt32 = '0;
    repeat (2) @(negedge clk);
    check("rst_probe", b8.probe, 0);
    check("rst_busy", b8.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst_result", b32.result, 0);
    check("rst_found", b8.found, 0);
    rst = 1'b0;

    for (int k = 0; k < 2; k++) begin
      w  = (k == 0) ? 8 : 32;
      mn = (w == 8) ? -32'sd128 : 32'sh8000_0000;
      mx = (w == 8) ?  32'sd127 : 32'sh7fff_ffff;
      search(w, 5, 4, 1'b1, 1'b0, w == 8);
      search(w, mn, mn, 1'b0, 1'b0, 1'b0);
      search(w, mx, mx - 1, 1'b1, 1'b0, 1'b0);
      search(w, 0, -1, 1'b1, 1'b0, 1'b0);
      search(w, -1, -2, 1'b1, 1'b0, 1'b0);
      search(w, 5, 4, 1'b1, 1'b1, 1'b0);
      search(w, 5, 4, 1'b1, 1'b0, 1'b0);
      search(w, -3, -4, 1'b1, 1'b0, 1'b0);
    end

    // Abort a search in its third SEARCH cycle with an asynchronous reset.
    @(negedge clk);
    tgt8 = 8'sd5;
    b8.start = 1'b1;
    e8.res = 4; e8.found = 1'b1; e8.cyc = cyc + 10;
    q8.push_back(e8);
    @(negedge clk);
    b8.start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_before_abort", b8.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_probe", b8.probe, 0);
    check("abort_busy", b8.busy, 0);
    check("abort_done", b8.done, 0);
    check("abort_result", b8.result, 0);
    check("abort_found", b8.found, 0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    search(8, 100, 99, 1'b1, 1'b0, 1'b0);
    search(32, 100, 99, 1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      t = $signed(32'($urandom()));
      if (t == 32'sh8000_0000) search(32, t, t, 1'b0, 1'b0, 1'b0);
      else                     search(32, t, t - 1, 1'b1, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("n8_queue_drained", q8.size(), 0);
    check("n32_queue_drained", q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
